// File: rtl/dtcm_ctrl.sv
// Data TCM responder: core/ext arbitration onto one single-port SRAM, with a
// 1-entry posted write buffer for core stores that is merged into buffer-hitting reads.
module dtcm_ctrl #(
  parameter int unsigned ADDR_W     = 14,
  parameter int unsigned STARVE_LIM = 4
) (
  input  logic              cpu_clk,
  input  logic              cpu_rst,
  input  logic              data_dtcm_access,
  output logic              data_dtcm_ready,
  input  logic              data_dtcm_rd0_wr1,
  input  logic [3:0]        data_dtcm_byte_strobe,
  input  logic [31:0]       data_dtcm_write_data,
  input  logic [31:0]       data_dtcm_addr,
  output logic [31:0]       data_dtcm_read_data,
  output logic              data_dtcm_read_data_valid,
  input  logic              ext_dtcm_req,
  output logic              ext_dtcm_gnt,
  input  logic              ext_dtcm_rd0_wr1,
  input  logic [3:0]        ext_dtcm_byte_strobe,
  input  logic [31:0]       ext_dtcm_write_data,
  input  logic [ADDR_W-1:0] ext_dtcm_addr,
  output logic [31:0]       ext_dtcm_read_data,
  output logic              ext_dtcm_read_data_valid,
  output logic              ram_cs,
  output logic              ram_we,
  output logic [3:0]        ram_wem,
  output logic [ADDR_W-3:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  localparam int unsigned WW = ADDR_W - 2;

  logic          wb_vld_q, wb_vld_d;
  logic [WW-1:0] wb_addr_q, wb_addr_d;
  logic [3:0]    wb_be_q, wb_be_d;
  logic [31:0]   wb_data_q, wb_data_d;
  logic [3:0]    starve_q, starve_d;
  logic          rd_pend_q, rd_pend_d;
  logic          rd_ext_q, rd_ext_d;
  logic [3:0]    mmask_q, mmask_d;
  logic [31:0]   mdata_q, mdata_d;
  logic [31:0]   core_rdata_q, core_rdata_d;
  logic [31:0]   ext_rdata_q, ext_rdata_d;

  logic [WW-1:0] core_waddr, ext_waddr;
  logic          core_rd, core_wr, hit_core, hit_ext, forced;
  logic          drain, ext_go, store_ok, rd_issue, rd_ext;
  logic [31:0]   rd_merged;

  assign core_waddr = data_dtcm_addr[ADDR_W-1:2];
  assign ext_waddr  = ext_dtcm_addr[ADDR_W-1:2];
  assign core_rd    = data_dtcm_access && !data_dtcm_rd0_wr1;
  assign core_wr    = data_dtcm_access && data_dtcm_rd0_wr1;
  assign hit_core   = wb_vld_q && (core_waddr == wb_addr_q);
  assign hit_ext    = wb_vld_q && (ext_waddr == wb_addr_q);
  assign forced     = (starve_q == 4'(STARVE_LIM)) && ext_dtcm_req;

  // Arbitration: decide the single SRAM owner and what happens to the buffer.
  always_comb begin
    drain           = 1'b0;
    ext_go          = 1'b0;
    store_ok        = 1'b0;
    rd_issue        = 1'b0;
    rd_ext          = 1'b0;
    data_dtcm_ready = 1'b1;
    if (core_rd) begin
      rd_issue = 1'b1;
    end else if (forced) begin
      drain  = hit_ext;
      ext_go = !hit_ext;
      if (core_wr) begin
        store_ok        = hit_core;
        data_dtcm_ready = hit_core;
      end
    end else if (core_wr && wb_vld_q && !hit_core) begin
      drain    = 1'b1;
      store_ok = 1'b1;
    end else if (ext_dtcm_req) begin
      drain    = hit_ext;
      ext_go   = !hit_ext;
      store_ok = core_wr;
    end else begin
      drain    = wb_vld_q;
      store_ok = core_wr;
    end
    if (ext_go && !ext_dtcm_rd0_wr1) begin
      rd_issue = 1'b1;
      rd_ext   = 1'b1;
    end
  end

  always_comb begin
    ram_cs       = 1'b0;
    ram_we       = 1'b0;
    ram_wem      = wb_be_q;
    ram_addr     = wb_addr_q;
    ram_wdata    = wb_data_q;
    ext_dtcm_gnt = 1'b0;
    if (core_rd) begin
      ram_cs   = 1'b1;
      ram_addr = core_waddr;
    end else if (ext_go) begin
      ext_dtcm_gnt = 1'b1;
      ram_cs       = 1'b1;
      ram_we       = ext_dtcm_rd0_wr1;
      ram_wem      = ext_dtcm_byte_strobe;
      ram_addr     = ext_waddr;
      ram_wdata    = ext_dtcm_write_data;
    end else if (drain) begin
      ram_cs = 1'b1;
      ram_we = 1'b1;
    end
    // Combinational strobes must stay quiet while reset is held.
    if (cpu_rst) begin
      ram_cs       = 1'b0;
      ext_dtcm_gnt = 1'b0;
    end
  end

  always_comb begin
    wb_vld_d  = wb_vld_q && !drain;
    wb_addr_d = wb_addr_q;
    wb_be_d   = wb_be_q;
    wb_data_d = wb_data_q;
    if (store_ok) begin
      wb_vld_d = 1'b1;
      if (hit_core) begin
        wb_be_d = wb_be_q | data_dtcm_byte_strobe;
        for (int i = 0; i < 4; i++) begin
          if (data_dtcm_byte_strobe[i]) wb_data_d[8*i +: 8] = data_dtcm_write_data[8*i +: 8];
        end
      end else begin
        wb_addr_d = core_waddr;
        wb_be_d   = data_dtcm_byte_strobe;
        wb_data_d = data_dtcm_write_data;
      end
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (ext_dtcm_gnt || !ext_dtcm_req) begin
      starve_d = '0;
    end else if (starve_q != 4'(STARVE_LIM)) begin
      starve_d = starve_q + 4'd1;
    end
  end

  always_comb begin
    rd_pend_d = rd_issue;
    rd_ext_d  = rd_ext;
    mdata_d   = wb_data_q;
    mmask_d   = '0;
    if (rd_ext ? hit_ext : hit_core) mmask_d = wb_be_q;
    for (int i = 0; i < 4; i++) begin
      rd_merged[8*i +: 8] = mmask_q[i] ? mdata_q[8*i +: 8] : ram_rdata[8*i +: 8];
    end
    core_rdata_d = (rd_pend_q && !rd_ext_q) ? rd_merged : core_rdata_q;
    ext_rdata_d  = (rd_pend_q && rd_ext_q) ? rd_merged : ext_rdata_q;
  end

  assign data_dtcm_read_data       = core_rdata_d;
  assign ext_dtcm_read_data        = ext_rdata_d;
  assign data_dtcm_read_data_valid = rd_pend_q && !rd_ext_q;
  assign ext_dtcm_read_data_valid  = rd_pend_q && rd_ext_q;

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      wb_vld_q     <= 1'b0;
      wb_addr_q    <= '0;
      wb_be_q      <= '0;
      wb_data_q    <= '0;
      starve_q     <= '0;
      rd_pend_q    <= 1'b0;
      rd_ext_q     <= 1'b0;
      mmask_q      <= '0;
      mdata_q      <= '0;
      core_rdata_q <= '0;
      ext_rdata_q  <= '0;
    end else begin
      wb_vld_q     <= wb_vld_d;
      wb_addr_q    <= wb_addr_d;
      wb_be_q      <= wb_be_d;
      wb_data_q    <= wb_data_d;
      starve_q     <= starve_d;
      rd_pend_q    <= rd_pend_d;
      rd_ext_q     <= rd_ext_d;
      mmask_q      <= mmask_d;
      mdata_q      <= mdata_d;
      core_rdata_q <= core_rdata_d;
      ext_rdata_q  <= ext_rdata_d;
    end
  end

endmodule

// File: doc/dtcm_ctrl.md
Name: dtcm_ctrl

Overview:
Data TCM responder. It sits at the far end of the core's data_dtcm_* interface and owns a single-port synchronous SRAM macro. A second requester (ext_*, e.g. DMA or debug) shares the SRAM through fixed-priority arbitration with an anti-starvation override. Core stores are posted into a 1-entry write buffer, drained when the SRAM port is free; reads that hit the buffer get its bytes merged in.

Parameters:
ADDR_W, 14, DTCM byte-address width (16 KB); SRAM word index = addr[ADDR_W-1:2]
STARVE_LIM, 4, consecutive ungranted ext cycles before ext is forced (1..15)

Ports:
cpu_clk  in  1  clock
cpu_rst  in  1  asynchronous reset, active-high
data_dtcm_access  in  1  core request, 1-cycle pulse per access
data_dtcm_ready  out  1  core store accepted this cycle
data_dtcm_rd0_wr1  in  1  0 read, 1 write
data_dtcm_byte_strobe  in  4  byte enables
data_dtcm_write_data  in  32  store data, lane-aligned
data_dtcm_addr  in  32  byte offset into DTCM; bits above ADDR_W ignored
data_dtcm_read_data  out  32  core read data
data_dtcm_read_data_valid  out  1  core read data valid pulse
ext_dtcm_req  in  1  ext request, held until granted
ext_dtcm_gnt  out  1  ext request accepted this cycle
ext_dtcm_rd0_wr1  in  1  0 read, 1 write
ext_dtcm_byte_strobe  in  4  byte enables
ext_dtcm_write_data  in  32  write data
ext_dtcm_addr  in  ADDR_W  byte address
ext_dtcm_read_data  out  32  ext read data
ext_dtcm_read_data_valid  out  1  ext read data valid pulse
ram_cs  out  1  SRAM chip select
ram_we  out  1  SRAM write enable
ram_wem  out  4  SRAM byte write mask
ram_addr  out  ADDR_W-2  SRAM word address
ram_wdata  out  32  SRAM write data
ram_rdata  in  32  SRAM read data, valid the cycle after cs&!we

Behaviour:
- Reset: wb_vld=0, starve_cnt=0, both read_data_valid=0, both read_data=0, ram_cs=0, ext_dtcm_gnt=0. Buffer contents are discarded; an in-flight read returns no valid. data_dtcm_ready=1 out of reset.
- Write buffer state: wb_vld, wb_addr (word), wb_be[3:0], wb_data[31:0].
- hit_core = wb_vld && core word addr == wb_addr. hit_ext is the same test on the ext address.
- forced = (starve_cnt == STARVE_LIM) && ext_dtcm_req.
- SRAM port priority, one owner per cycle:
  1. Core read. Always accepted, because the core never retries a load.
  2. Forced ext. If hit_ext, a drain is issued instead and ext is granted the next cycle.
  3. Drain required by a core store with wb_vld && !hit_core.
  4. Ext request. If hit_ext, a drain is issued instead and gnt=0.
  5. Idle drain when wb_vld.
- Core store handling:
  - !wb_vld: load the buffer.
  - hit_core: merge into the buffer per byte strobe; new bytes win; wb_be |= strobe.
  - Otherwise: drain the old entry this cycle, then load the new one.
  - data_dtcm_ready=0 only when forced, a store is present, and !hit_core. The core holds the store; it is accepted when ready=1.
- Drain: ram_cs=1, ram_we=1, ram_wem=wb_be, ram_addr=wb_addr, ram_wdata=wb_data. wb_vld clears unless reloaded in the same cycle.
- Reads:
  - Issue cycle: ram_cs=1, ram_we=0. Register a source tag (core/ext), merge mask = hit ? wb_be : 0, and merge data = wb_data.
  - Next cycle: read_data = per byte, the buffer byte where the mask is set, else ram_rdata. The matching read_data_valid pulses for 1 cycle; the other port's valid stays 0.
  - read_data holds its last value otherwise.
- Ext writes go straight to SRAM; ram_wem = ext strobe. ext_dtcm_gnt is combinational, in the same cycle as the SRAM access.
- starve_cnt:
  - Cleared on gnt or when !ext_dtcm_req.
  - Otherwise increments, saturating at STARVE_LIM.
  - Core reads may still preempt a forced cycle; starve_cnt stays saturated until ext is granted.
- Idle: ram_cs=0; ram_we, ram_wem, ram_addr, ram_wdata are don't-care but driven from the buffer.

Test Plan:
- Core store 0x10 data 0xAABBCCDD be 1111, then core read 0x10 next cycle -> no SRAM write between; valid pulse one cycle after the read with 0xAABBCCDD (full merge).
- SRAM word 0x20 preloaded 0x11223344. Store be 0010 data 0x00005500 to 0x20, idle, read 0x20 -> idle cycle ram_we=1 wem=0010; read returns 0x11225544.
- Stores to 0x30 then 0x34 on consecutive cycles -> ready=1 both; cycle 2 drains 0x30 (ram_addr=0x0C); buffer holds 0x34.
- ext_dtcm_req held while the core stores to a new address every cycle -> gnt=0 for 4 cycles; 5th cycle gnt=1, data_dtcm_ready=0, store accepted the following cycle.
- Buffer holds 0x40; ext write to 0x40 -> cycle N drain (wem=wb_be), gnt=0; N+1 gnt=1 with the ext write.
- Assert cpu_rst mid-cycle with the buffer full and a read in flight -> outputs clear asynchronously; after release no drain and no valid pulse.
